// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR coefficient path.
// Tap count, coefficient width/type, loader state encoding.
package fir_pkg;

  localparam int N_TAPS = 64;
  localparam int COEF_W = 16;
  localparam int AW     = 6;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/fir_coef_ram.sv
// N_TAPS x COEF_W coefficient register file.
// Ports: clk2, we/waddr/wdata sync write, raddr/rdata comb read.
module fir_coef_ram
  import fir_pkg::*;
(
  input  logic          clk2,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  coef_t         wdata,
  input  logic [AW-1:0] raddr,
  output coef_t         rdata
);

  coef_t mem [N_TAPS];

  always_ff @(posedge clk2) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_coef_loader.sv
// Buffers N_TAPS coefficients from a valid/ready stream and replays them
// one per clk2 onto ALU b, then holds b_valid. Macro: FIR_COEF_PARITY_EN.
// Ports: clk2, ALU_restn, s_valid/s_data/s_ready (+s_parity), load_start,
// clear, b, b_strobe, b_valid, busy, err.
module fir_coef_loader
  import fir_pkg::*;
(
  input  logic              clk2,
  input  logic              ALU_restn,
  input  logic              s_valid,
  input  logic [COEF_W-1:0] s_data,
`ifdef FIR_COEF_PARITY_EN
  input  logic              s_parity,
`endif
  output logic              s_ready,
  input  logic              load_start,
  input  logic              clear,
  output logic [COEF_W-1:0] b,
  output logic              b_strobe,
  output logic              b_valid,
  output logic              busy,
  output logic              err
);

  localparam logic [AW-1:0] LAST = AW'(N_TAPS - 1);

  ld_state_e     state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          last;
  logic          par_ok;
  logic          accept;
  logic          wr_en;
  coef_t         rd_data;

`ifdef FIR_COEF_PARITY_EN
  assign par_ok = (s_parity == ^s_data);
`else
  assign par_ok = 1'b1;
`endif

  assign s_ready = (state == FILL);
  assign busy    = (state == STREAM);
  assign accept  = s_valid && s_ready && !clear;
  assign wr_en   = accept && par_ok;

  fir_coef_ram u_ram (
    .clk2  (clk2),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (coef_t'(s_data)),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // last marks that tap N_TAPS-1 is already on b, so the next
  // edge closes the replay without rd_ptr wrapping.
  always_ff @(posedge clk2 or negedge ALU_restn) begin
    if (!ALU_restn) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last     <= 1'b0;
      b        <= '0;
      b_strobe <= 1'b0;
      b_valid  <= 1'b0;
      err      <= 1'b0;
    end else if (clear) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last     <= 1'b0;
      b        <= '0;
      b_strobe <= 1'b0;
      b_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (wr_en) begin
            if (wr_ptr == LAST) state <= FULL;
            else wr_ptr <= wr_ptr + AW'(1);
          end
`ifdef FIR_COEF_PARITY_EN
          if (accept && !par_ok) err <= 1'b1;
`endif
        end
        FULL: begin
          if (load_start && !err) begin
            state  <= STREAM;
            rd_ptr <= '0;
            last   <= 1'b0;
          end
        end
        STREAM: begin
          if (!last) begin
            b        <= rd_data;
            b_strobe <= 1'b1;
            if (rd_ptr == LAST) last <= 1'b1;
            else rd_ptr <= rd_ptr + AW'(1);
          end else begin
            b_strobe <= 1'b0;
            b_valid  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader: fill, replay, clear, reset
// abort and (with FIR_COEF_PARITY_EN) parity error handling.
module tb_fir_coef_loader;
  import fir_pkg::*;

  logic        clk2 = 1'b0;
  logic        ALU_restn = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_parity = 1'b0;
  logic        load_start = 1'b0;
  logic        clear = 1'b0;
  logic        s_ready;
  logic [15:0] b;
  logic        b_strobe;
  logic        b_valid;
  logic        busy;
  logic        err;

  fir_coef_loader dut (
    .clk2       (clk2),
    .ALU_restn  (ALU_restn),
    .s_valid    (s_valid),
    .s_data     (s_data),
`ifdef FIR_COEF_PARITY_EN
    .s_parity   (s_parity),
`endif
    .s_ready    (s_ready),
    .load_start (load_start),
    .clear      (clear),
    .b          (b),
    .b_strobe   (b_strobe),
    .b_valid    (b_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk2 = ~clk2;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_mem [64];
  int          model_wp = 0;
  logic        model_err = 1'b0;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gen(input int kind, input int i);
    logic [15:0] v;
    v = 16'(i + 1);
    if (kind == 1) begin
      case (i % 4)
        0: v = 16'h8000;
        1: v = 16'h7FFF;
        2: v = 16'hFFFF;
        default: v = 16'(i) ^ 16'h5A00;
      endcase
    end
    return v;
  endfunction

  function automatic void model_reset();
    model_wp  = 0;
    model_err = 1'b0;
    exp_q.delete();
  endfunction

  task automatic push_word(input logic [15:0] d,
                           input bit rnd,
                           input bit bad);
    bit done;
    bit bad_eff;
    int guard;
    done  = 0;
    guard = 0;
`ifdef FIR_COEF_PARITY_EN
    bad_eff = bad;
`else
    bad_eff = 1'b0;
`endif
    while (!done) begin
      @(negedge clk2);
      s_data   = d;
      s_parity = (^d) ^ bad;
      s_valid  = (rnd && guard < 8) ?
                 1'($urandom_range(0, 1)) : 1'b1;
      guard++;
      if (s_valid) begin
        done = 1;
        chk("s_ready", 32'(s_ready), 32'(model_wp < 64));
        if (model_wp < 64) begin
          if (bad_eff) model_err = 1'b1;
          else begin
            model_mem[model_wp] = d;
            model_wp++;
          end
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk2);
    s_valid = 1'b0;
  endtask

  task automatic fill(input int kind, input bit rnd);
    for (int i = 0; i < 64; i++) push_word(gen(kind, i), rnd, 1'b0);
    idle();
  endtask

  task automatic do_clear();
    @(negedge clk2);
    clear = 1'b1;
    @(negedge clk2);
    clear = 1'b0;
    model_reset();
    chk("clr_b_valid", 32'(b_valid), 0);
    chk("clr_s_ready", 32'(s_ready), 1);
    chk("clr_err", 32'(err), 0);
  endtask

  // abort: 0 none, 1 clear at index 'at', 2 reset at index 'at'
  task automatic replay(input int abort, input int at);
    @(negedge clk2);
    load_start = 1'b1;
    foreach (model_mem[i]) exp_q.push_back(model_mem[i]);
    @(negedge clk2);
    load_start = 1'b0;
    chk("busy_k", 32'(busy), 1);
    chk("strobe_k", 32'(b_strobe), 0);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk2);
      if (c <= 64) begin
        if (b_strobe && exp_q.size() > 0)
          chk("b", 32'(b), 32'(exp_q.pop_front()));
        else
          chk("strobe", 32'(b_strobe), 1);
        if (c == 64) chk("valid_early", 32'(b_valid), 0);
        if (abort == 1 && c == at + 1) begin
          clear = 1'b1;
          @(negedge clk2);
          clear = 1'b0;
          chk("clr_b", 32'(b), 0);
          chk("clr_strobe", 32'(b_strobe), 0);
          chk("clr_valid", 32'(b_valid), 0);
          chk("clr_busy", 32'(busy), 0);
          chk("clr_state", 32'(dut.state), 0);
          model_reset();
          return;
        end
        if (abort == 2 && c == at + 1) begin
          ALU_restn = 1'b0;
          #1;
          chk("rst_b", 32'(b), 0);
          chk("rst_strobe", 32'(b_strobe), 0);
          chk("rst_valid", 32'(b_valid), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_err", 32'(err), 0);
          @(negedge clk2);
          ALU_restn = 1'b1;
          @(negedge clk2);
          chk("rst_s_ready", 32'(s_ready), 1);
          chk("rst_valid2", 32'(b_valid), 0);
          model_reset();
          return;
        end
      end else begin
        chk("done_valid", 32'(b_valid), 1);
        chk("done_strobe", 32'(b_strobe), 0);
        chk("done_b", 32'(b), 32'(model_mem[63]));
        chk("done_busy", 32'(busy), 0);
        chk("q_empty", 32'(exp_q.size()), 0);
        return;
      end
    end
  endtask

  task automatic done_hold();
    @(negedge clk2);
    load_start = 1'b1;
    s_valid    = 1'b1;
    @(negedge clk2);
    load_start = 1'b0;
    s_valid    = 1'b0;
    repeat (2) begin
      @(negedge clk2);
      chk("hold_strobe", 32'(b_strobe), 0);
      chk("hold_valid", 32'(b_valid), 1);
      chk("hold_b", 32'(b), 32'(model_mem[63]));
    end
    chk("hold_s_ready", 32'(s_ready), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_b0", 32'(b), 0);
    chk("rst_strobe0", 32'(b_strobe), 0);
    chk("rst_valid0", 32'(b_valid), 0);
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_err0", 32'(err), 0);
    chk("rst_ready0", 32'(s_ready), 1);
    @(negedge clk2);
    ALU_restn = 1'b1;

    fill(0, 1'b0);
    chk("full_state", 32'(dut.state), 1);
    chk("full_ready", 32'(s_ready), 0);
    push_word(16'h0041, 1'b0, 1'b0);
    idle();
    replay(0, 0);
    done_hold();
    do_clear();

    fill(1, 1'b1);
    replay(0, 0);
    do_clear();

    fill(0, 1'b1);
    replay(1, 20);
    fill(1, 1'b0);
    replay(0, 0);
    do_clear();

    fill(0, 1'b0);
    replay(2, 30);
    fill(1, 1'b1);
    chk("refill_valid", 32'(b_valid), 0);
    replay(0, 0);
    chk("err_default", 32'(err), 0);

`ifdef FIR_COEF_PARITY_EN
    do_clear();
    for (int i = 0; i < 5; i++) push_word(gen(0, i), 1'b0, 1'b0);
    push_word(16'h0003, 1'b0, 1'b1);
    idle();
    chk("par_err", 32'(err), 1);
    chk("par_wp", 32'(dut.wr_ptr), 5);
    chk("par_ready", 32'(s_ready), 1);
    while (model_wp < 64) push_word(gen(0, model_wp), 1'b0, 1'b0);
    idle();
    chk("par_full_ready", 32'(s_ready), 0);
    @(negedge clk2);
    load_start = 1'b1;
    @(negedge clk2);
    load_start = 1'b0;
    repeat (3) begin
      @(negedge clk2);
      chk("par_no_strobe", 32'(b_strobe), 0);
      chk("par_no_busy", 32'(busy), 0);
    end
    do_clear();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
